// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the EX-stage issue logic and alu_muldiv.
// Latency: none, wires only.
// Backpressure: i_valid/o_ready handshake on requests; o_valid is a one-cycle pulse with no stall.
interface alu_muldiv_if #(
    parameter int DWIDTH = 32,
    parameter int FWIDTH = 5
);
    logic              i_valid;
    logic              o_ready;
    logic [DWIDTH-1:0] i_data_rs;
    logic [DWIDTH-1:0] i_data_rt;
    logic [FWIDTH-1:0] i_funct;
    logic              o_valid;
    logic [DWIDTH-1:0] o_alu_value;
    logic              o_zero;
    logic              o_overflow;

    modport master (
        output i_valid, i_data_rs, i_data_rt, i_funct,
        input  o_ready, o_valid, o_alu_value, o_zero, o_overflow
    );

    modport slave (
        input  i_valid, i_data_rs, i_data_rt, i_funct,
        output o_ready, o_valid, o_alu_value, o_zero, o_overflow
    );
endinterface

// File: rtl/alu_muldiv.sv
// Clocked MIPS ALU; with ALU_MULDIV_EN adds iterative MULT/MULTU/DIV/DIVU into HI/LO plus MFHI/MFLO.
// Latency: single-cycle ops 1 cycle; multiply/divide DWIDTH+1 cycles from accept to result pulse.
// Backpressure: o_ready drops while multiply/divide runs and requests are ignored; without ALU_MULDIV_EN o_ready is tied high.
module alu_muldiv #(
    parameter int DWIDTH = 32,
    parameter int FWIDTH = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    alu_muldiv_if.slave a
);
    localparam int MSB = DWIDTH - 1;
    localparam int SHW = $clog2(DWIDTH);

    localparam logic [FWIDTH-1:0] F_ADD  = FWIDTH'(0);
    localparam logic [FWIDTH-1:0] F_SUB  = FWIDTH'(1);
    localparam logic [FWIDTH-1:0] F_AND  = FWIDTH'(2);
    localparam logic [FWIDTH-1:0] F_OR   = FWIDTH'(3);
    localparam logic [FWIDTH-1:0] F_XOR  = FWIDTH'(4);
    localparam logic [FWIDTH-1:0] F_NOR  = FWIDTH'(5);
    localparam logic [FWIDTH-1:0] F_SLT  = FWIDTH'(6);
    localparam logic [FWIDTH-1:0] F_SLTU = FWIDTH'(7);
    localparam logic [FWIDTH-1:0] F_SLL  = FWIDTH'(8);
    localparam logic [FWIDTH-1:0] F_SRL  = FWIDTH'(9);
    localparam logic [FWIDTH-1:0] F_SRA  = FWIDTH'(10);

    logic [DWIDTH-1:0] rs, rt;
    logic [SHW-1:0]    shamt;
    logic [DWIDTH-1:0] add_res, sub_res;
    logic [DWIDTH-1:0] alu_res;
    logic              alu_ovf;
    logic              accept;
    logic              is_multi;
    logic              fix_vld;
    logic [DWIDTH-1:0] fix_lo;

    logic              res_vld;
    logic [DWIDTH-1:0] res_dat;
    logic              res_zero;
    logic              res_ovf;

    assign rs      = a.i_data_rs;
    assign rt      = a.i_data_rt;
    assign shamt   = rs[SHW-1:0];
    assign add_res = rs + rt;
    assign sub_res = rs - rt;
    assign accept  = a.i_valid & a.o_ready;

`ifdef ALU_MULDIV_EN
    localparam int CW = $clog2(DWIDTH + 1);

    localparam logic [FWIDTH-1:0] F_MULT  = FWIDTH'(11);
    localparam logic [FWIDTH-1:0] F_MULTU = FWIDTH'(12);
    localparam logic [FWIDTH-1:0] F_DIV   = FWIDTH'(13);
    localparam logic [FWIDTH-1:0] F_DIVU  = FWIDTH'(14);
    localparam logic [FWIDTH-1:0] F_MFHI  = FWIDTH'(16);
    localparam logic [FWIDTH-1:0] F_MFLO  = FWIDTH'(17);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [DWIDTH-1:0]   hi, lo;
    logic [DWIDTH-1:0]   opb;          // multiplicand or divisor magnitude
    logic [2*DWIDTH-1:0] work;         // {acc, multiplier} or {remainder, dividend/quotient}
    logic                neg_q, neg_r, is_div;
    logic                op_signed, op_div;
    logic [DWIDTH-1:0]   rs_abs, rt_abs;
    logic [DWIDTH-1:0]   mul_add;
    logic [DWIDTH:0]     mul_sum;
    logic [2*DWIDTH-1:0] mul_nxt;
    logic [DWIDTH:0]     div_sh;
    logic [DWIDTH+1:0]   div_trial;
    logic [2*DWIDTH-1:0] div_nxt;
    logic [2*DWIDTH-1:0] mul_full;
    logic [DWIDTH-1:0]   fix_hi;

    assign is_multi  = (a.i_funct == F_MULT) || (a.i_funct == F_MULTU) ||
                       (a.i_funct == F_DIV)  || (a.i_funct == F_DIVU);
    assign op_signed = (a.i_funct == F_MULT) || (a.i_funct == F_DIV);
    assign op_div    = (a.i_funct == F_DIV)  || (a.i_funct == F_DIVU);
    assign rs_abs    = (op_signed && rs[MSB]) ? -rs : rs;
    assign rt_abs    = (op_signed && rt[MSB]) ? -rt : rt;
    assign a.o_ready = (state == S_IDLE);
    assign fix_vld   = (state == S_FIX);
`else
    assign is_multi  = 1'b0;
    assign a.o_ready = 1'b1;
    assign fix_vld   = 1'b0;
    assign fix_lo    = '0;
`endif

    // Single-cycle result and overflow for the current request
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (a.i_funct)
            F_ADD: begin
                alu_res = add_res;
                alu_ovf = (rs[MSB] == rt[MSB]) && (add_res[MSB] != rs[MSB]);
            end
            F_SUB: begin
                alu_res = sub_res;
                alu_ovf = (rs[MSB] != rt[MSB]) && (sub_res[MSB] != rs[MSB]);
            end
            F_AND:  alu_res = rs & rt;
            F_OR:   alu_res = rs | rt;
            F_XOR:  alu_res = rs ^ rt;
            F_NOR:  alu_res = ~(rs | rt);
            F_SLT:  alu_res = {{(DWIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
            F_SLTU: alu_res = {{(DWIDTH-1){1'b0}}, (rs < rt)};
            F_SLL:  alu_res = rt << shamt;
            F_SRL:  alu_res = rt >> shamt;
            F_SRA:  alu_res = $signed(rt) >>> shamt;
`ifdef ALU_MULDIV_EN
            F_MFHI: alu_res = hi;
            F_MFLO: alu_res = lo;
`endif
            default: ;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state: one pass of DWIDTH iterations, then one sign-fix cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (accept && is_multi) state_nxt = op_div ? S_DIV : S_MUL;
            S_MUL, S_DIV: if (cnt == CW'(1)) state_nxt = S_FIX;
            S_FIX:        state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // One shift-add multiply step and one restoring divide step on unsigned magnitudes
    always_comb begin
        mul_add   = work[0] ? opb : '0;
        mul_sum   = {1'b0, work[2*DWIDTH-1:DWIDTH]} + {1'b0, mul_add};
        mul_nxt   = {mul_sum, work[DWIDTH-1:1]};
        div_sh    = work[2*DWIDTH-1:DWIDTH-1];
        // extra top bit keeps the borrow separate from a shifted-in remainder MSB
        div_trial = {1'b0, div_sh} - {2'b00, opb};
        if (div_trial[DWIDTH+1])
            div_nxt = {div_sh[DWIDTH-1:0], work[DWIDTH-2:0], 1'b0};
        else
            div_nxt = {div_trial[DWIDTH-1:0], work[DWIDTH-2:0], 1'b1};
    end

    // Sign correction and divide-by-zero override applied in S_FIX
    always_comb begin
        mul_full = neg_q ? -work : work;
        fix_hi   = mul_full[2*DWIDTH-1:DWIDTH];
        fix_lo   = mul_full[DWIDTH-1:0];
        if (is_div) begin
            fix_hi = neg_r ? -work[2*DWIDTH-1:DWIDTH] : work[2*DWIDTH-1:DWIDTH];
            fix_lo = (opb == '0) ? '1 : (neg_q ? -work[DWIDTH-1:0] : work[DWIDTH-1:0]);
        end
    end

    // Iterative datapath: latch magnitudes on accept, then step once per cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            work   <= '0;
            opb    <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_multi) begin
                        cnt    <= CW'(DWIDTH);
                        neg_q  <= op_signed & (rs[MSB] ^ rt[MSB]);
                        neg_r  <= op_signed & rs[MSB];
                        is_div <= op_div;
                        if (op_div) begin
                            work <= {{DWIDTH{1'b0}}, rs_abs};
                            opb  <= rt_abs;
                        end else begin
                            work <= {{DWIDTH{1'b0}}, rt_abs};
                            opb  <= rs_abs;
                        end
                    end
                end
                S_MUL: begin
                    work <= mul_nxt;
                    cnt  <= cnt - CW'(1);
                end
                S_DIV: begin
                    work <= div_nxt;
                    cnt  <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // HI/LO update when a multiply/divide completes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hi <= '0;
            lo <= '0;
        end else if (fix_vld) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end
    end
`endif

    // Registered result, flags and one-cycle valid pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            res_vld  <= 1'b0;
            res_dat  <= '0;
            res_zero <= 1'b0;
            res_ovf  <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            if (fix_vld) begin
                res_vld  <= 1'b1;
                res_dat  <= fix_lo;
                res_zero <= (fix_lo == '0);
                res_ovf  <= 1'b0;
            end else if (accept && !is_multi) begin
                res_vld  <= 1'b1;
                res_dat  <= alu_res;
                res_zero <= (alu_res == '0);
                res_ovf  <= alu_ovf;
            end
        end
    end

    assign a.o_valid     = res_vld;
    assign a.o_alu_value = res_dat;
    assign a.o_zero      = res_zero;
    assign a.o_overflow  = res_ovf;
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised, clocked successor to the combinational MIPS ALU. Executes single-cycle integer ops with registered result and flags. Executes MIPS MULT/MULTU/DIV/DIVU iteratively into internal HI/LO registers, with MFHI/MFLO readback. Sits in the EX stage behind a valid/ready handshake so the pipeline stalls while a multiply or divide is in flight.

Parameters:
DWIDTH, 32, operand/result width (even, >= 8)
FWIDTH, 5, function-code width (fixed encoding below; must be >= 5)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
a_i_valid  in  1  operation request
a_o_ready  out  1  block can accept an op this cycle
a_i_data_rs  in  DWIDTH  operand A / shift amount
a_i_data_rt  in  DWIDTH  operand B / shifted value
a_i_funct  in  FWIDTH  operation select
a_o_valid  out  1  result valid, one-cycle pulse
a_o_alu_value  out  DWIDTH  registered result
a_o_zero  out  1  a_o_alu_value == 0, qualified by a_o_valid
a_o_overflow  out  1  signed overflow for ADD/SUB, qualified by a_o_valid

Behaviour:
- Reset: outputs a_o_valid, a_o_alu_value, a_o_zero and a_o_overflow go to 0. HI and LO go to 0, state goes to S_IDLE, iteration counter goes to 0. a_o_ready = 1 once i_rst deasserts. Reset mid-operation aborts the op with no result pulse.
- Accept = a_i_valid & a_o_ready at a rising edge. a_o_ready = (state == S_IDLE), combinational from state.
- Funct encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA: shift rt by rs[$clog2(DWIDTH)-1:0].
  - 11 MULT, 12 MULTU, 13 DIV, 14 DIVU.
  - 16 MFHI, 17 MFLO.
  - 15 and 18-31 are illegal: result 0, flags 0, single-cycle.
- Single-cycle ops (all except 11-14):
  - Result, zero and overflow are registered on the accepting edge.
  - a_o_valid is high for exactly the following cycle.
  - Back-to-back accepts every cycle are allowed.
- ADD/SUB are modulo 2^DWIDTH. Overflow = operand signs cause a sign flip. All other ops: overflow = 0.
- Multi-cycle ops (11-14), state machine S_IDLE -> S_MUL|S_DIV -> S_FIX -> S_IDLE:
  - On the accepting edge, operands are latched and made absolute for signed ops, sign flags are saved, and the counter is set to DWIDTH.
  - S_MUL: one shift-add step per cycle. S_DIV: one restoring step per cycle. Counter decrements; leave when it reaches 1.
  - S_FIX: apply sign correction, write HI/LO, set a_o_alu_value = new LO and zero = (LO == 0), pulse a_o_valid, return to S_IDLE.
  - Latency: a_o_valid is high in the cycle after the (DWIDTH+1)th edge following accept. a_o_ready is low for DWIDTH+1 cycles.
  - a_i_valid is ignored while busy. The latched operands make input changes while busy harmless.
- Multiply: {HI,LO} = full 2*DWIDTH product, signed for MULT, unsigned for MULTU.
- Divide:
  - LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = rs. Same latency.
  - DIV of most-negative by -1: LO = most-negative, HI = 0.
- MFHI/MFLO issued immediately after a multi-cycle op's valid pulse return the updated HI/LO.

Optional Feature:
ALU_MULDIV_EN.
- Defined: HI/LO, S_MUL/S_DIV/S_FIX and functs 11-14, 16, 17 behave as above.
- Undefined: no HI/LO or iterative datapath is built, and a_o_ready is tied to 1. Functs 11-14, 16 and 17 are treated as illegal (single-cycle, result 0).

Test Plan:
- ADD rs=5 rt=4 -> next cycle valid=1, value=9, zero=0, ovf=0. SUB rs=4 rt=4 -> value=0, zero=1. ADD 0x7FFFFFFF+1 -> value=0x80000000, ovf=1.
- Back-to-back AND, OR, XOR, SLT(rs=-1, rt=1), SLTU(rs=-1, rt=1), SRA(rt=0x80000000, rs=4), one per cycle -> six consecutive valid pulses with values 4, 5, 1, 1, 0, 0xF8000000 for the first three using rs=5 rt=4.
- MULT rs=-3 rt=7 -> ready low 33 cycles, valid 33 cycles after accept, LO=0xFFFFFFEB. MFHI -> 0xFFFFFFFF. MULTU 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE.
- DIV rs=-7 rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Assert i_rst 10 cycles into a DIV -> all outputs 0 immediately, no valid pulse, ready=1 after release, MFLO returns 0.
- Compile without ALU_MULDIV_EN: MULT rs=3 rt=4 -> valid next cycle, value=0, ready never drops.
